// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the multicycle MIPS control path.
//   state_e   : control FSM states
//   iclass_e  : instruction classes produced by ctrl_decode
//   OP_*/FN_* : opcode and R-type funct encodings
//   ALU_*     : alu_op codes
//   SRCB_*    : alu_src_b mux encodings (shared with the datapath)
//   PCSRC_*   : pc_source mux encodings (shared with the datapath)
//   EXC_*     : exc_cause encodings
package ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RESET,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_JR,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_RD_WAIT,
    ST_WB_LW,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_EXC_SAVE,
    ST_EXC_JUMP
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_JR,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_INVALID
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_IMM     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_REGB    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic EXC_OVERFLOW = 1'b0;
  localparam logic EXC_INVALID  = 1'b1;

  // Conditional-branch decision: beq on zero, bne on not-zero.
  function automatic logic branch_taken(input iclass_e cls, input logic zero);
    return ((cls == CLS_BEQ) && zero) || ((cls == CLS_BNE) && !zero);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational instruction classifier.
//   opcode   in  IR[31:26]
//   funct    in  IR[5:0]
//   iclass   out instruction class (CLS_INVALID for unsupported encodings)
//   r_alu_op out ALU operation for R-type execute (OR for jr pass-through)
//   ovf_chk  out instruction traps on signed overflow (add, sub, addi)
//   invalid  out opcode/funct combination is not supported
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic [2:0] r_alu_op,
  output logic       ovf_chk,
  output logic       invalid
);

  always_comb begin
    iclass   = CLS_INVALID;
    r_alu_op = ALU_NOP;
    ovf_chk  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin iclass = CLS_RTYPE; r_alu_op = ALU_ADD; ovf_chk = 1'b1; end
          FN_SUB: begin iclass = CLS_RTYPE; r_alu_op = ALU_SUB; ovf_chk = 1'b1; end
          FN_AND: begin iclass = CLS_RTYPE; r_alu_op = ALU_AND; end
          FN_OR:  begin iclass = CLS_RTYPE; r_alu_op = ALU_OR;  end
          FN_SLT: begin iclass = CLS_RTYPE; r_alu_op = ALU_SLT; end
          // jr routes reg A through ALUOut as A | $zero
          FN_JR:  begin iclass = CLS_JR;    r_alu_op = ALU_OR;  end
          default: ;
        endcase
      end
      OP_ADDI: begin iclass = CLS_ADDI; ovf_chk = 1'b1; end
      OP_LW:   iclass = CLS_LW;
      OP_SW:   iclass = CLS_SW;
      OP_BEQ:  iclass = CLS_BEQ;
      OP_BNE:  iclass = CLS_BNE;
      OP_J:    iclass = CLS_J;
      default: ;
    endcase
  end

  assign invalid = (iclass == CLS_INVALID);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- Moore control FSM for the multicycle MIPS datapath.
// Optional feature macro: MULTICYCLE_CTRL_EXCEPTION_EN (overflow / invalid
// opcode exceptions through EXC_SAVE and EXC_JUMP). Without it, overflow is
// ignored and invalid encodings retire as a NOP.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   opcode, funct         instruction-register fields
//   zero, overflow        ALU flags (current cycle)
//   pc_write, pc_source   PC load enable / PC source select
//   iord                  memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write   memory strobes
//   ir_write              IR load enable
//   reg_write, reg_dst    register-file write enable / dest select
//   mem_to_reg            write-back data select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation
//   epc_write, exc_cause  EPC load enable / exception cause
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       epc_write,
  output logic       exc_cause
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [2:0] r_alu_op;
  logic       ovf_chk;
  logic       invalid;

  ctrl_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .iclass   (iclass),
    .r_alu_op (r_alu_op),
    .ovf_chk  (ovf_chk),
    .invalid  (invalid)
  );

`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
  logic cause_q, cause_d;
`else
  logic unused_flags;
  assign unused_flags = overflow ^ ovf_chk;
`endif

  // Next-state logic. Invalid encodings (bad opcode or bad R-type funct)
  // are resolved in DECODE so the exception path is DECODE + 2 cycles.
  always_comb begin
    state_d = state_q;
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
    cause_d = cause_q;
`endif
    case (state_q)
      ST_RESET:      state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: state_d = ST_DECODE;
      ST_DECODE: begin
        if (invalid) begin
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
          state_d = ST_EXC_SAVE;
          cause_d = EXC_INVALID;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          case (iclass)
            CLS_RTYPE, CLS_JR: state_d = ST_EXEC_R;
            CLS_ADDI:          state_d = ST_EXEC_I;
            CLS_LW, CLS_SW:    state_d = ST_MEM_ADDR;
            CLS_BEQ, CLS_BNE:  state_d = ST_BRANCH;
            CLS_J:             state_d = ST_JUMP;
            default:           state_d = ST_FETCH;
          endcase
        end
      end
      ST_EXEC_R: begin
        if (iclass == CLS_JR) state_d = ST_JR;
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
        else if (ovf_chk && overflow) begin
          state_d = ST_EXC_SAVE;
          cause_d = EXC_OVERFLOW;
        end
`endif
        else state_d = ST_WB_R;
      end
      ST_EXEC_I: begin
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
        if (ovf_chk && overflow) begin
          state_d = ST_EXC_SAVE;
          cause_d = EXC_OVERFLOW;
        end else
`endif
        state_d = ST_WB_I;
      end
      ST_MEM_ADDR:    state_d = (iclass == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:      state_d = ST_MEM_RD_WAIT;
      ST_MEM_RD_WAIT: state_d = ST_WB_LW;
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
      ST_EXC_SAVE:    state_d = ST_EXC_JUMP;
`endif
      default:        state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
      cause_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
      cause_q <= cause_d;
`endif
    end
  end

  // Output decode from the state register. Because reset forces state_q to
  // ST_RESET asynchronously, every strobe drops as soon as reset rises.
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_IMM;
    alu_op     = ALU_NOP;
    epc_write  = 1'b0;
    exc_cause  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_source = PCSRC_ALU;
        pc_write  = 1'b1;
      end
      ST_FETCH_WAIT: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALU_ADD;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = r_alu_op;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_ALUOUT;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_WB_I: reg_write = 1'b1;
      ST_MEM_RD, ST_MEM_RD_WAIT: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        // only Mealy output: depends on the live zero flag
        pc_write  = branch_taken(iclass, zero);
      end
      ST_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
      ST_EXC_SAVE: begin
        // ALU computes PC-4 (address of the faulting instruction) for EPC
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_SUB;
        epc_write = 1'b1;
        exc_cause = cause_q;
      end
      ST_EXC_JUMP: begin
        pc_source = PCSRC_EXC;
        pc_write  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected output
// vector for each cycle; a monitor pops and compares on the falling edge.
// Vector layout: {pc_write, pc_source[1:0], iord, mem_read, mem_write,
//   ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0],
//   alu_op[2:0], epc_write, exc_cause}
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, epc_write, exc_cause;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic       mid_chk = 1'b0;

  typedef struct {
    logic [17:0] e;
    string       nm;
  } item_t;
  item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .pc_write(pc_write),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .epc_write(epc_write),
    .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  logic [17:0] act;
  assign act = {pc_write, pc_source, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                epc_write, exc_cause};

  //                              p ss i r w I W d m a bb ooo e c
  localparam logic [17:0] E_RST   = 18'b0_00_0_0_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_FETCH = 18'b1_00_0_1_0_0_0_0_0_0_01_001_0_0;
  localparam logic [17:0] E_FW    = 18'b0_00_0_1_0_1_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_DEC   = 18'b0_00_0_0_0_0_0_0_0_0_11_001_0_0;
  localparam logic [17:0] E_WBR   = 18'b0_00_0_0_0_0_1_1_0_0_00_000_0_0;
  localparam logic [17:0] E_JR    = 18'b1_01_0_0_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_EXI   = 18'b0_00_0_0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [17:0] E_WBI   = 18'b0_00_0_0_0_0_1_0_0_0_00_000_0_0;
  localparam logic [17:0] E_MRD   = 18'b0_00_1_1_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_WBLW  = 18'b0_00_0_0_0_0_1_0_1_0_00_000_0_0;
  localparam logic [17:0] E_MWR   = 18'b0_00_1_0_1_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_BR0   = 18'b0_01_0_0_0_0_0_0_0_1_10_010_0_0;
  localparam logic [17:0] E_BR1   = 18'b1_01_0_0_0_0_0_0_0_1_10_010_0_0;
  localparam logic [17:0] E_JMP   = 18'b1_10_0_0_0_0_0_0_0_0_00_000_0_0;
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
  localparam logic [17:0] E_XS0   = 18'b0_00_0_0_0_0_0_0_0_0_01_010_1_0;
  localparam logic [17:0] E_XS1   = 18'b0_00_0_0_0_0_0_0_0_0_01_010_1_1;
  localparam logic [17:0] E_XJMP  = 18'b1_11_0_0_0_0_0_0_0_0_00_000_0_0;
`endif

  // R-type execute: alu_src_a=1, alu_src_b=10, alu_op given
  function automatic logic [17:0] e_exr(input logic [2:0] aop);
    return {11'b0_00_0_0_0_0_0_0_0_1, 2'b10, aop, 2'b00};
  endfunction

  task automatic push(input logic [17:0] e, input string nm);
    item_t it;
    it.e  = e;
    it.nm = nm;
    sb.push_back(it);
  endtask

  task automatic cyc(input logic [17:0] e, input string nm);
    @(posedge clk);
    #1;
    push(e, nm);
  endtask

  // First cycle of an instruction: inputs change only after the previous
  // instruction's last cycle has been sampled.
  task automatic start(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov, input string nm);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z; overflow = ov;
    push(E_FETCH, nm);
  endtask

  // Monitor
  initial begin
    item_t it;
    forever begin
      @(negedge clk or posedge mid_chk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_cmp++;
        if (act !== it.e) begin
          n_err++;
          $display("FAIL %s: got %b expected %b", it.nm, act, it.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] fns  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] aops [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
  logic [5:0] bops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
  logic       bz   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       btk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    @(posedge clk); #1;
    push(E_RST, "reset_held");
    @(posedge clk); #1;
    reset = 1'b0;
    push(E_RST, "reset_release");

    // R-type ALU ops; the next instruction's FETCH checks the return
    for (int i = 0; i < 5; i++) begin
      start(6'h00, fns[i], 1'b0, 1'b0, $sformatf("r%0d_fetch", i));
      cyc(E_FW, $sformatf("r%0d_fw", i));
      cyc(E_DEC, $sformatf("r%0d_dec", i));
      cyc(e_exr(aops[i]), $sformatf("r%0d_exec", i));
      cyc(E_WBR, $sformatf("r%0d_wb", i));
    end

    start(6'h00, 6'h08, 1'b0, 1'b0, "jr_fetch");
    cyc(E_FW, "jr_fw"); cyc(E_DEC, "jr_dec");
    cyc(e_exr(3'b100), "jr_exec"); cyc(E_JR, "jr_pc");

    start(6'h08, 6'h00, 1'b0, 1'b0, "addi_fetch");
    cyc(E_FW, "addi_fw"); cyc(E_DEC, "addi_dec");
    cyc(E_EXI, "addi_exec"); cyc(E_WBI, "addi_wb");

    start(6'h23, 6'h00, 1'b0, 1'b0, "lw_fetch");
    cyc(E_FW, "lw_fw"); cyc(E_DEC, "lw_dec"); cyc(E_EXI, "lw_addr");
    cyc(E_MRD, "lw_rd"); cyc(E_MRD, "lw_rd_wait"); cyc(E_WBLW, "lw_wb");

    start(6'h2B, 6'h00, 1'b0, 1'b0, "sw_fetch");
    cyc(E_FW, "sw_fw"); cyc(E_DEC, "sw_dec"); cyc(E_EXI, "sw_addr");
    cyc(E_MWR, "sw_wr");

    for (int i = 0; i < 4; i++) begin
      start(bops[i], 6'h00, bz[i], 1'b0, $sformatf("br%0d_fetch", i));
      cyc(E_FW, $sformatf("br%0d_fw", i));
      cyc(E_DEC, $sformatf("br%0d_dec", i));
      cyc(btk[i] ? E_BR1 : E_BR0, $sformatf("br%0d_branch", i));
    end

    start(6'h02, 6'h00, 1'b0, 1'b0, "j_fetch");
    cyc(E_FW, "j_fw"); cyc(E_DEC, "j_dec"); cyc(E_JMP, "j_jump");

    start(6'h3F, 6'h00, 1'b0, 1'b0, "badop_fetch");
    cyc(E_FW, "badop_fw"); cyc(E_DEC, "badop_dec");
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
    cyc(E_XS1, "badop_save"); cyc(E_XJMP, "badop_vec");
`endif

    start(6'h00, 6'h3F, 1'b0, 1'b0, "badfn_fetch");
    cyc(E_FW, "badfn_fw"); cyc(E_DEC, "badfn_dec");
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
    cyc(E_XS1, "badfn_save"); cyc(E_XJMP, "badfn_vec");
`endif

    start(6'h00, 6'h20, 1'b0, 1'b1, "addovf_fetch");
    cyc(E_FW, "addovf_fw"); cyc(E_DEC, "addovf_dec");
    cyc(e_exr(3'b001), "addovf_exec");
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
    cyc(E_XS0, "addovf_save"); cyc(E_XJMP, "addovf_vec");
`else
    cyc(E_WBR, "addovf_wb");
`endif

    start(6'h08, 6'h00, 1'b0, 1'b1, "addiovf_fetch");
    cyc(E_FW, "addiovf_fw"); cyc(E_DEC, "addiovf_dec");
    cyc(E_EXI, "addiovf_exec");
`ifdef MULTICYCLE_CTRL_EXCEPTION_EN
    cyc(E_XS0, "addiovf_save"); cyc(E_XJMP, "addiovf_vec");
`else
    cyc(E_WBI, "addiovf_wb");
`endif

    // and never traps on overflow
    start(6'h00, 6'h24, 1'b0, 1'b1, "andovf_fetch");
    cyc(E_FW, "andovf_fw"); cyc(E_DEC, "andovf_dec");
    cyc(e_exr(3'b011), "andovf_exec"); cyc(E_WBR, "andovf_wb");

    // reset rising mid MEM_WR must drop mem_write within that cycle
    start(6'h2B, 6'h00, 1'b0, 1'b0, "swrst_fetch");
    cyc(E_FW, "swrst_fw"); cyc(E_DEC, "swrst_dec"); cyc(E_EXI, "swrst_addr");
    cyc(E_MWR, "swrst_wr");
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    push(E_RST, "swrst_async");
    mid_chk = 1'b1;
    #1;
    mid_chk = 1'b0;
    cyc(E_RST, "swrst_held");
    reset = 1'b0;

    start(6'h02, 6'h00, 1'b0, 1'b0, "post_rst_fetch");
    cyc(E_FW, "post_rst_fw"); cyc(E_DEC, "post_rst_dec");
    cyc(E_JMP, "post_rst_jump");
    cyc(E_FETCH, "final_fetch");

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
